// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture dump path
// Contents: Address (9-bit RAM address), SAMPLE_DEPTH (samples per record), state_t (dump FSM states)
package capture_pkg;
  typedef logic [8:0] Address;
  localparam int SAMPLE_DEPTH = 512;
  typedef enum logic [2:0] {IDLE, READ, WAIT_DATA, SEND, WAIT_TX, DONE} state_t;
endpackage

// File: rtl/dump_ctrl.sv
// dump_ctrl: streams a full capture record to a UART, oldest sample first
// Ports: clk, rst (async, active high); capture_done, start_dump, abort, last_addr (control);
//   ram_en, ram_addr, ram_rdata (capture RAM read, 1-cycle latency);
//   tx_data, tx_start, tx_busy, tx_done (UART handshake); busy, dump_finished, clr_capture_done (status)
// Option: DUMP_CHECKSUM_EN appends the mod-256 sum of all samples as one extra byte
module dump_ctrl
  import capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       capture_done,
  input  logic       start_dump,
  input  logic       abort,
  input  logic [8:0] last_addr,
  output logic       ram_en,
  output logic [8:0] ram_addr,
  input  logic [7:0] ram_rdata,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       busy,
  output logic       dump_finished,
  output logic       clr_capture_done
);
  state_t r_state, w_next, w_after_tx;
  Address r_ptr, r_cnt;
  logic [7:0] r_tx_data;
  logic w_last, w_adv;
  assign w_last = r_cnt == Address'(SAMPLE_DEPTH - 1);
`ifdef DUMP_CHECKSUM_EN
  logic [7:0] r_sum;
  logic r_csum;
  // the checksum byte reuses SEND/WAIT_TX; its completion finishes the dump
  assign w_after_tx = r_csum ? DONE : (w_last ? SEND : READ);
  assign w_adv = r_state == WAIT_TX && tx_done && !abort && !r_csum;
`else
  assign w_after_tx = w_last ? DONE : READ;
  assign w_adv = r_state == WAIT_TX && tx_done && !abort;
`endif
  always_comb begin
    w_next = r_state;
    if (abort)
      w_next = IDLE;
    else
      case (r_state)
        IDLE:      w_next = (start_dump && capture_done) ? READ : IDLE;
        READ:      w_next = WAIT_DATA;
        WAIT_DATA: w_next = SEND;
        SEND:      w_next = tx_busy ? SEND : WAIT_TX;
        WAIT_TX:   w_next = tx_done ? w_after_tx : WAIT_TX;
        default:   w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_tx_data <= '0;
`ifdef DUMP_CHECKSUM_EN
      r_sum     <= '0;
      r_csum    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == READ) begin
        r_ptr <= last_addr + 9'd1;
        r_cnt <= '0;
`ifdef DUMP_CHECKSUM_EN
        r_sum  <= '0;
        r_csum <= 1'b0;
`endif
      end
      if (r_state == WAIT_DATA) begin
        r_tx_data <= ram_rdata;
`ifdef DUMP_CHECKSUM_EN
        r_sum <= r_sum + ram_rdata;
`endif
      end
      if (w_adv) begin
        r_ptr <= r_ptr + 9'd1;
        r_cnt <= r_cnt + 9'd1;
      end
`ifdef DUMP_CHECKSUM_EN
      if (w_adv && w_last) begin
        r_csum    <= 1'b1;
        r_tx_data <= r_sum;
      end
`endif
    end
  end
  assign busy             = r_state != IDLE;
  assign ram_en           = r_state == READ;
  assign ram_addr         = r_ptr;
  assign tx_data          = r_tx_data;
  assign tx_start         = r_state == SEND && !tx_busy;
  // an abort landing on DONE cancels the completion pulses too
  assign dump_finished    = r_state == DONE && !abort;
  assign clr_capture_done = r_state == DONE && !abort;
endmodule

// File: doc/dump_ctrl.md
DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset; all ports are listed below, clock and reset first.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 capture_done  in  1  level; the capture buffer holds a complete record.
REQ-005 start_dump  in  1  single-cycle request to dump the record.
REQ-006 abort  in  1  single-cycle request to cancel a dump.
REQ-007 last_addr  in  9  Address of the final sample written; stable while capture_done=1.
REQ-008 ram_en  out  1  read enable to the capture RAM.
REQ-009 ram_addr  out  9  read Address.
REQ-010 ram_rdata  in  8  read data, valid one cycle after ram_en.
REQ-011 tx_data  out  8  byte to the UART transmitter.
REQ-012 tx_start  out  1  single-cycle send strobe.
REQ-013 tx_busy  in  1  transmitter cannot accept a byte.
REQ-014 tx_done  in  1  single-cycle pulse when a byte has finished sending.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 dump_finished  out  1  single-cycle pulse when a dump completes.
REQ-017 clr_capture_done  out  1  single-cycle pulse that rearms capture; asserted together with dump_finished.

Function
REQ-018 The state machine SHALL have the states IDLE, READ, WAIT_DATA, SEND, WAIT_TX and DONE.
REQ-019 IDLE SHALL go to READ on start_dump=1 with capture_done=1; start_dump with capture_done=0 SHALL be ignored.
REQ-020 On leaving IDLE the read pointer SHALL load last_addr+1 (mod 512) and the sample count SHALL clear to 0.
REQ-021 READ SHALL assert ram_en with ram_addr equal to the pointer for one cycle, then go to WAIT_DATA.
REQ-022 WAIT_DATA SHALL register ram_rdata into tx_data, then go to SEND.
REQ-023 SEND SHALL hold while tx_busy=1; when tx_busy=0 it SHALL assert tx_start for exactly one cycle and go to WAIT_TX.
REQ-024 WAIT_TX SHALL wait for tx_done, then advance the pointer by 1 (wrapping 511 to 0) and the count by 1.
REQ-025 After tx_done: if the count was 511, go to DONE; otherwise go to READ.
REQ-026 DONE SHALL pulse dump_finished and clr_capture_done for one cycle, then go to IDLE.
REQ-027 Latency: with tx_busy=0 from the start, start_dump sampled at edge N SHALL give ram_en in cycle N+1 and tx_start in cycle N+3.
REQ-028 Every dump SHALL send exactly 512 samples, oldest first, in circular order.
REQ-029 abort in any non-IDLE state SHALL return to IDLE on the next edge, with no dump_finished or clr_capture_done pulse.
REQ-030 abort and start_dump in the same cycle SHALL leave the block in IDLE, because abort has priority.
REQ-031 start_dump while busy=1 SHALL be ignored.
REQ-032 A tx_done received outside WAIT_TX SHALL be ignored.

Reset
REQ-033 While rst=1, state SHALL be IDLE and ram_en, tx_start, busy, dump_finished, clr_capture_done, tx_data, ram_addr, the pointer and the count SHALL all be 0.
REQ-034 Reset asserted mid-dump SHALL abandon the dump immediately, with no completion pulses.

Configuration
REQ-035 With DUMP_CHECKSUM_EN defined, after the 512th tx_done the block SHALL send one extra byte: the sum of all 512 samples mod 256, using the SEND/WAIT_TX handshake, before entering DONE.
REQ-036 With DUMP_CHECKSUM_EN undefined, no checksum logic SHALL exist and exactly 512 bytes SHALL be sent.

Structure
REQ-037 The package capture_pkg SHALL hold typedef Address (logic[8:0]), the constant SAMPLE_DEPTH=512 and the state enum.
REQ-038 The block SHALL be a single module with no sub-modules; the RAM and the UART are external.

Verification
REQ-039 last_addr=100, capture_done=1, start_dump pulse, single-cycle tx_done 10 cycles after each tx_start -> ram_addr sequence 101..511,0..100; 512 tx_start pulses; one dump_finished.
REQ-040 last_addr=511 -> first ram_addr=0 and last ram_addr=511.
REQ-041 tx_busy held high for 50 cycles while in SEND -> tx_start is delayed until tx_busy falls; no samples are lost.
REQ-042 abort after the 200th tx_done -> IDLE on the next edge; dump_finished stays 0; capture_done stays set.
REQ-043 start_dump with capture_done=0, and start_dump together with abort -> busy stays 0.
REQ-044 DUMP_CHECKSUM_EN defined, RAM filled with 0x01 -> 513 bytes sent, the last byte 0x00 (512 mod 256).
